// File: rtl/mm_tile_seq_ctrl.sv
// Tile sequencer for the 4x4x4x16 matrix-multiply datapath: walks an M x N x K tile grid.
// Define MM_CTRL_PERF_EN to add the perf_stall / perf_busy cycle counters.
module mm_tile_seq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 4,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_m_tiles,
  input  logic [CNT_W-1:0]  cfg_n_tiles,
  input  logic [CNT_W-1:0]  cfg_k_tiles,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              mm_enable,
  output logic              acc_en,
  output logic              acc_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr
`ifdef MM_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_busy
`endif
);

  localparam int PW        = 2 * CNT_W;
  localparam int WAIT_LAST = (MULT_LAT > 1) ? MULT_LAT - 2 : 0;
  localparam int WCW       = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_WRITE,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  m_cnt, n_cnt, k_cnt;
  logic [CNT_W-1:0]  m_cfg, n_cfg, k_cfg;
  logic [WCW-1:0]    wait_cnt;
  logic              err_flag;
  logic [ADDR_W-1:0] act_hold, wgt_hold;

  logic              cfg_zero;
  logic              k_last, n_last, m_last, wait_last;
  logic [PW-1:0]     act_prod, wgt_prod, out_prod;

  assign cfg_zero  = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);
  assign k_last    = (k_cnt == k_cfg - CNT_W'(1));
  assign n_last    = (n_cnt == n_cfg - CNT_W'(1));
  assign m_last    = (m_cnt == m_cfg - CNT_W'(1));
  assign wait_last = (wait_cnt == WCW'(WAIT_LAST));

  // Tile indices are formed at double counter width, then truncated to the address width.
  assign act_prod = PW'(m_cnt) * PW'(k_cfg) + PW'(k_cnt);
  assign wgt_prod = PW'(k_cnt) * PW'(n_cfg) + PW'(n_cnt);
  assign out_prod = PW'(m_cnt) * PW'(n_cfg) + PW'(n_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mm_enable = 1'b0;
    acc_en    = 1'b0;
    acc_first = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    act_addr  = act_hold;
    wgt_addr  = wgt_hold;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = cfg_zero ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy      = 1'b1;
        mm_enable = 1'b1;
        act_addr  = ADDR_W'(act_prod);
        wgt_addr  = ADDR_W'(wgt_prod);
        state_nxt = (MULT_LAT == 1) ? S_ACC : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_last) begin
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        busy      = 1'b1;
        acc_en    = 1'b1;
        acc_first = (k_cnt == '0);
        state_nxt = k_last ? S_WRITE : S_ISSUE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = ADDR_W'(out_prod);
        if (out_ready) begin
          state_nxt = (m_last && n_last) ? S_FIN : S_ISSUE;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        err       = err_flag;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch and the m/n/k walk; addresses are held between ISSUE cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt    <= '0;
      n_cnt    <= '0;
      k_cnt    <= '0;
      m_cfg    <= '0;
      n_cfg    <= '0;
      k_cfg    <= '0;
      wait_cnt <= '0;
      err_flag <= 1'b0;
      act_hold <= '0;
      wgt_hold <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !cfg_zero) begin
            m_cfg <= cfg_m_tiles;
            n_cfg <= cfg_n_tiles;
            k_cfg <= cfg_k_tiles;
            m_cnt <= '0;
            n_cnt <= '0;
            k_cnt <= '0;
          end else if (start) begin
            err_flag <= 1'b1;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          act_hold <= ADDR_W'(act_prod);
          wgt_hold <= ADDR_W'(wgt_prod);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
        S_ACC: begin
          if (!k_last) begin
            k_cnt <= k_cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (out_ready) begin
            k_cnt <= '0;
            if (n_last) begin
              n_cnt <= '0;
              m_cnt <= m_cnt + CNT_W'(1);
            end else begin
              n_cnt <= n_cnt + CNT_W'(1);
            end
          end
        end
        S_FIN: begin
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MM_CTRL_PERF_EN
  // Saturating counters, restarted by any start seen in IDLE and frozen once the job ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall <= '0;
      perf_busy  <= '0;
    end else if (state == S_IDLE && start) begin
      perf_stall <= '0;
      perf_busy  <= '0;
    end else begin
      if (busy && perf_busy != '1) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if (state == S_WRITE && !out_ready && perf_stall != '1) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mm_tile_seq_ctrl.sv
// Directed self-checking bench for mm_tile_seq_ctrl (default parameters, MULT_LAT=2).
// Cycle 0 is the cycle in which start is presented; outputs are sampled 1 ns after each rising edge.
module tb_mm_tile_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] cfg_m_tiles, cfg_n_tiles, cfg_k_tiles;
  logic       busy, done, err;
  logic [7:0] act_addr, wgt_addr, out_addr;
  logic       mm_enable, acc_en, acc_first, out_valid, out_ready;
`ifdef MM_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_busy;
`endif

  int total = 0;
  int bad   = 0;

  int act_q[$], wgt_q[$], accf_q[$], ack_q[$];
  int mm_cnt, busy_cycles, done_cnt, err_cnt, done_cycle, err_at_done;
  int first_mm, first_acc, first_ov, stall_seen, stall_bad, ov_stall_cycles;
  bit timed_out;

  mm_tile_seq_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_m_tiles(cfg_m_tiles),
    .cfg_n_tiles(cfg_n_tiles),
    .cfg_k_tiles(cfg_k_tiles),
    .busy(busy),
    .done(done),
    .err(err),
    .act_addr(act_addr),
    .wgt_addr(wgt_addr),
    .mm_enable(mm_enable),
    .acc_en(acc_en),
    .acc_first(acc_first),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr)
`ifdef MM_CTRL_PERF_EN
    ,
    .perf_stall(perf_stall),
    .perf_busy(perf_busy)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE and records what the DUT does until three cycles after done.
  task automatic run_job(input int m, input int n, input int k, input int stall_addr,
                         input int stall_len, input bit noise);
    int c;
    int stall_rem;
    act_q.delete(); wgt_q.delete(); accf_q.delete(); ack_q.delete();
    mm_cnt = 0; busy_cycles = 0; done_cnt = 0; err_cnt = 0;
    done_cycle = -1; err_at_done = 0;
    first_mm = -1; first_acc = -1; first_ov = -1;
    stall_seen = 0; stall_bad = 0; ov_stall_cycles = 0; timed_out = 0;
    stall_rem = stall_len;
    cfg_m_tiles = 4'(m);
    cfg_n_tiles = 4'(n);
    cfg_k_tiles = 4'(k);
    out_ready = 1'b1;
    start = 1'b1;
    c = 0;
    while (1) begin
      step();
      c++;
      start = 1'b0;
      if (noise && busy) begin
        cfg_m_tiles = 4'($urandom_range(0, 15));
        cfg_n_tiles = 4'($urandom_range(0, 15));
        cfg_k_tiles = 4'($urandom_range(0, 15));
        if (c % 4 == 1) start = 1'b1;
      end
      out_ready = 1'b1;
      if (out_valid && out_addr == stall_addr) begin
        ov_stall_cycles++;
        if (stall_rem > 0) begin
          out_ready = 1'b0;
          stall_rem--;
          stall_seen++;
          if (mm_enable) stall_bad++;
        end
      end
      if (mm_enable) begin
        mm_cnt++;
        act_q.push_back(int'(act_addr));
        wgt_q.push_back(int'(wgt_addr));
        if (first_mm < 0) first_mm = c;
      end
      if (acc_en) begin
        accf_q.push_back(int'(acc_first));
        if (first_acc < 0) first_acc = c;
      end
      if (out_valid && first_ov < 0) first_ov = c;
      if (out_valid && out_ready) ack_q.push_back(int'(out_addr));
      if (busy) busy_cycles++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle = c;
          err_at_done = int'(err);
        end
      end
      if (done_cycle >= 0 && c >= done_cycle + 3) break;
      if (c >= 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    cfg_m_tiles = '0; cfg_n_tiles = '0; cfg_k_tiles = '0;
    step();
    step();
    total++;
    if ({busy, done, err, mm_enable, acc_en, acc_first, out_valid} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, err, mm_enable, acc_en, acc_first, out_valid});
    end
    total++;
    if ({act_addr, wgt_addr, out_addr} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL reset_addr: got %h expected 000000", {act_addr, wgt_addr, out_addr});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_minimal();
    run_job(1, 1, 1, -1, 0, 1'b0);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL min_timeout: got 1 expected 0"); end
    total++;
    if (first_mm !== 1) begin bad++; $display("[TB] FAIL min_issue_cycle: got %0d expected 1", first_mm); end
    total++;
    if (act_q.size() != 1 || act_q[0] !== 0 || wgt_q[0] !== 0) begin
      bad++; $display("[TB] FAIL min_addrs: got count %0d expected 1 with act=wgt=0", act_q.size());
    end
    total++;
    if (first_acc !== 3) begin bad++; $display("[TB] FAIL min_acc_cycle: got %0d expected 3", first_acc); end
    total++;
    if (accf_q.size() != 1 || accf_q[0] !== 1) begin
      bad++; $display("[TB] FAIL min_acc_first: got count %0d expected one load", accf_q.size());
    end
    total++;
    if (first_ov !== 4) begin bad++; $display("[TB] FAIL min_valid_cycle: got %0d expected 4", first_ov); end
    total++;
    if (ack_q.size() != 1 || ack_q[0] !== 0) begin
      bad++; $display("[TB] FAIL min_out_addr: got count %0d expected one tile at 0", ack_q.size());
    end
    total++;
    if (done_cycle !== 5) begin bad++; $display("[TB] FAIL min_done_cycle: got %0d expected 5", done_cycle); end
    total++;
    if (busy_cycles !== 4) begin bad++; $display("[TB] FAIL min_busy: got %0d expected 4", busy_cycles); end
    total++;
    if (err_cnt !== 0) begin bad++; $display("[TB] FAIL min_err: got %0d expected 0", err_cnt); end
  endtask

  // Shared expectations for the 2x3x2 job, with an optional stall added to the timing.
  task automatic check_full(input string tag, input int extra);
    int tt, kk, mi, ni;
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL %s_timeout: got 1 expected 0", tag); end
    total++;
    if (mm_cnt !== 12) begin bad++; $display("[TB] FAIL %s_mm_count: got %0d expected 12", tag, mm_cnt); end
    total++;
    if (act_q.size() == 12 && (act_q[11] !== 3 || wgt_q[11] !== 5)) begin
      bad++; $display("[TB] FAIL %s_last_step_addr: got act=%0d wgt=%0d expected act=3 wgt=5",
                      tag, act_q[11], wgt_q[11]);
    end
    for (int i = 0; i < 12 && i < act_q.size(); i++) begin
      tt = i / 2; kk = i % 2; mi = tt / 3; ni = tt % 3;
      total++;
      if (act_q[i] !== mi * 2 + kk || wgt_q[i] !== kk * 3 + ni) begin
        bad++; $display("[TB] FAIL %s_addr_seq[%0d]: got act=%0d wgt=%0d expected act=%0d wgt=%0d",
                        tag, i, act_q[i], wgt_q[i], mi * 2 + kk, kk * 3 + ni);
      end
    end
    total++;
    if (accf_q.size() != 12) begin
      bad++; $display("[TB] FAIL %s_acc_count: got %0d expected 12", tag, accf_q.size());
    end
    for (int i = 0; i < accf_q.size(); i++) begin
      total++;
      if (accf_q[i] !== ((i % 2 == 0) ? 1 : 0)) begin
        bad++; $display("[TB] FAIL %s_acc_first[%0d]: got %0d expected %0d", tag, i, accf_q[i], (i % 2 == 0) ? 1 : 0);
      end
    end
    total++;
    if (ack_q.size() != 6) begin bad++; $display("[TB] FAIL %s_tile_count: got %0d expected 6", tag, ack_q.size()); end
    for (int i = 0; i < ack_q.size(); i++) begin
      total++;
      if (ack_q[i] !== i) begin bad++; $display("[TB] FAIL %s_out_addr[%0d]: got %0d expected %0d", tag, i, ack_q[i], i); end
    end
    total++;
    if (busy_cycles !== 42 + extra) begin
      bad++; $display("[TB] FAIL %s_busy: got %0d expected %0d", tag, busy_cycles, 42 + extra);
    end
    total++;
    if (done_cycle !== 43 + extra) begin
      bad++; $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", tag, done_cycle, 43 + extra);
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++; $display("[TB] FAIL %s_done_err: got done=%0d err=%0d expected done=1 err=0", tag, done_cnt, err_cnt);
    end
  endtask

  task automatic test_full_job();
    run_job(2, 3, 2, -1, 0, 1'b0);
    check_full("full", 0);
`ifdef MM_CTRL_PERF_EN
    total++;
    if (perf_busy !== 32'd42 || perf_stall !== 32'd0) begin
      bad++; $display("[TB] FAIL full_perf: got busy=%0d stall=%0d expected busy=42 stall=0", perf_busy, perf_stall);
    end
`endif
  endtask

  task automatic test_backpressure();
    run_job(2, 3, 2, 2, 5, 1'b0);
    check_full("bp", 5);
    total++;
    if (stall_seen !== 5 || ov_stall_cycles !== 6) begin
      bad++; $display("[TB] FAIL bp_hold: got stalled=%0d valid_cycles=%0d expected 5 and 6", stall_seen, ov_stall_cycles);
    end
    total++;
    if (stall_bad !== 0) begin bad++; $display("[TB] FAIL bp_no_issue: got %0d expected 0", stall_bad); end
`ifdef MM_CTRL_PERF_EN
    total++;
    if (perf_stall !== 32'd5 || perf_busy !== 32'd47) begin
      bad++; $display("[TB] FAIL bp_perf: got stall=%0d busy=%0d expected stall=5 busy=47", perf_stall, perf_busy);
    end
`endif
  endtask

  task automatic test_zero_config();
    run_job(2, 3, 0, -1, 0, 1'b0);
    total++;
    if (mm_cnt !== 0) begin bad++; $display("[TB] FAIL zero_mm: got %0d expected 0", mm_cnt); end
    total++;
    if (done_cycle !== 1 || err_at_done !== 1) begin
      bad++; $display("[TB] FAIL zero_done_err: got cycle=%0d err=%0d expected cycle=1 err=1", done_cycle, err_at_done);
    end
    total++;
    if (busy_cycles !== 0) begin bad++; $display("[TB] FAIL zero_busy: got %0d expected 0", busy_cycles); end
    total++;
    if (done_cnt !== 1 || err_cnt !== 1) begin
      bad++; $display("[TB] FAIL zero_pulses: got done=%0d err=%0d expected 1 and 1", done_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_midjob();
    int dn;
    cfg_m_tiles = 4'd2; cfg_n_tiles = 4'd3; cfg_k_tiles = 4'd2;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    total++;
    if ({busy, mm_enable, acc_en, out_valid} !== 4'b1000) begin
      bad++; $display("[TB] FAIL rst_mid_in_wait: got %b expected 1000", {busy, mm_enable, acc_en, out_valid});
    end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, err, mm_enable, acc_en, acc_first, out_valid, act_addr, wgt_addr, out_addr} !== 31'h0) begin
      bad++; $display("[TB] FAIL rst_mid_outputs: got %h expected 0",
                      {busy, done, err, mm_enable, acc_en, acc_first, out_valid, act_addr, wgt_addr, out_addr});
    end
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) dn++;
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (done || busy) dn++;
    end
    total++;
    if (dn !== 0) begin bad++; $display("[TB] FAIL rst_mid_no_done: got %0d expected 0", dn); end
    run_job(1, 1, 1, -1, 0, 1'b0);
    total++;
    if (act_q.size() != 1 || act_q[0] !== 0) begin
      bad++; $display("[TB] FAIL rst_mid_restart_addr: got count %0d expected one issue at act 0", act_q.size());
    end
    total++;
    if (done_cnt !== 1 || done_cycle !== 5) begin
      bad++; $display("[TB] FAIL rst_mid_restart_done: got count=%0d cycle=%0d expected 1 and 5", done_cnt, done_cycle);
    end
  endtask

  task automatic test_ignored_start();
    run_job(2, 3, 2, -1, 0, 1'b1);
    check_full("ign", 0);
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_full_job();
    test_backpressure();
    test_zero_config();
    test_reset_midjob();
    test_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
